// File: rtl/branch_pc_unit_if.sv
// Fetch-sequencer control/status bundle for branch_pc_unit.
// TakenCount exists only when BRANCH_COUNT_EN is defined.
interface branch_pc_unit_if #(
    parameter int PC_W = 10
);
    logic            Start;
    logic            Stall;
    logic            HaltReq;
    logic            BranchEn;
    logic [2:0]      BranchOp;
    logic [PC_W-1:0] Target;
    logic            FlagWe;
    logic            FlagEq;
    logic            FlagGt;
    logic [PC_W-1:0] PC;
    logic            Running;
    logic            Done;
    logic            Taken;
`ifdef BRANCH_COUNT_EN
    logic [15:0]     TakenCount;
`endif

    modport master (
        output Start, Stall, HaltReq, BranchEn, BranchOp, Target,
        output FlagWe, FlagEq, FlagGt,
`ifdef BRANCH_COUNT_EN
        input  TakenCount,
`endif
        input  PC, Running, Done, Taken
    );

    modport slave (
        input  Start, Stall, HaltReq, BranchEn, BranchOp, Target,
        input  FlagWe, FlagEq, FlagGt,
`ifdef BRANCH_COUNT_EN
        output TakenCount,
`endif
        output PC, Running, Done, Taken
    );
endinterface

// File: rtl/branch_pc_unit.sv
// Program counter / branch resolution stage ahead of fetch, with Start/Done handshake.
// Optional BRANCH_COUNT_EN adds a saturating 16-bit taken-branch counter.
module branch_pc_unit #(
    parameter int PC_W = 10
) (
    input logic             Clk,
    input logic             Reset_n,
    branch_pc_unit_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_HALT = 2'b10;

    localparam logic [2:0] kBEA = 3'b000;
    localparam logic [2:0] kBER = 3'b001;
    localparam logic [2:0] kBNA = 3'b010;
    localparam logic [2:0] kBNR = 3'b011;
    localparam logic [2:0] kBUN = 3'b100;
    localparam logic [2:0] kBGT = 3'b101;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    // Offset is already PC_W wide, so a plain PC_W-bit add is the sign-extended wrap.
    function automatic logic [PC_W-1:0] rel_target(input logic [PC_W-1:0] pc,
                                                   input logic [PC_W-1:0] off);
        return pc + off;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [1:0]      state_q, state_n;
    logic [PC_W-1:0] pc_q, pc_n, pc_inc;
    logic            eq_q, gt_q;
    logic            taken_q, taken_n;
    logic            br_cond;
    logic [PC_W-1:0] br_dest;
    logic            start_acc;
    logic            flag_upd;

    assign pc_inc    = pc_q + PC_ONE;
    assign start_acc = bus.Start && ((state_q == S_IDLE) || (state_q == S_HALT));
    assign flag_upd  = bus.FlagWe && !bus.Stall;

    // Conditions see only the registered flags, so a same-cycle FlagWe is not yet visible.
    always_comb begin
        br_cond = 1'b0;
        br_dest = pc_inc;
        case (bus.BranchOp)
            kBEA: begin br_cond = eq_q;  br_dest = bus.Target;                   end
            kBER: begin br_cond = eq_q;  br_dest = rel_target(pc_q, bus.Target); end
            kBNA: begin br_cond = !eq_q; br_dest = bus.Target;                   end
            kBNR: begin br_cond = !eq_q; br_dest = rel_target(pc_q, bus.Target); end
            kBUN: begin br_cond = 1'b1;  br_dest = bus.Target;                   end
            kBGT: begin br_cond = gt_q;  br_dest = rel_target(pc_q, bus.Target); end
            default: begin br_cond = 1'b0; br_dest = pc_inc;                     end
        endcase
    end

    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        taken_n = 1'b0;
        case (state_q)
            S_IDLE: begin
                pc_n = '0;
                if (start_acc) state_n = S_RUN;
            end
            S_RUN: begin
                if (!bus.Stall) begin
                    if (bus.HaltReq) begin
                        state_n = S_HALT;
                    end else if (bus.BranchEn && br_cond) begin
                        pc_n    = br_dest;
                        taken_n = 1'b1;
                    end else begin
                        pc_n = pc_inc;
                    end
                end
            end
            S_HALT: begin
                if (start_acc) begin
                    state_n = S_RUN;
                    pc_n    = '0;
                end
            end
            default: begin
                state_n = S_IDLE;
                pc_n    = '0;
            end
        endcase
    end

    // State register boundary
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            taken_q <= taken_n;
            if (flag_upd) begin
                eq_q <= bus.FlagEq;
                gt_q <= bus.FlagGt;
            end
        end
    end

    assign bus.PC      = pc_q;
    assign bus.Running = (state_q == S_RUN);
    assign bus.Done    = (state_q == S_HALT);
    assign bus.Taken   = taken_q;

`ifdef BRANCH_COUNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q <= '0;
        end else if (start_acc) begin
            cnt_q <= '0;
        end else if (taken_n) begin
            cnt_q <= sat_inc16(cnt_q);
        end
    end

    assign bus.TakenCount = cnt_q;
`else
    logic unused_sat;
    assign unused_sat = ^sat_inc16(16'd0);
`endif

endmodule
